// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared RISC-V datapath definitions for the immediate generator:
//            immediate format encoding and the base opcodes that carry an
//            immediate field.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // 000..011 keep the legacy 2-bit ImmSrc meaning so existing control
    // units can drive the low bits unchanged.
    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_ILL   = 3'b111
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imm_fmt_decode.sv
`default_nettype none
// ============================================================================
// Module   : imm_fmt_decode
// Purpose  : Combinational immediate-format selection. With AUTO_DECODE=0 the
//            control unit's imm_src is passed straight through; with
//            AUTO_DECODE=1 the format is derived from opcode/funct3 and
//            imm_src is ignored.
// Ports    : instr   (in, 32) raw instruction word
//            imm_src (in, 3)  externally supplied format
//            fmt     (out, 3) selected format (imm_fmt_e encoding)
//            illegal (out, 1) format is unsupported
// Revision : 1.0 - initial release
// ============================================================================
module imm_fmt_decode
    import riscv_pkg::*;
#(
    parameter int AUTO_DECODE = 0
) (
    input  logic [31:0] instr,
    input  logic [2:0]  imm_src,
    output logic [2:0]  fmt,
    output logic        illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    imm_fmt_e   w_auto_fmt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    always_comb begin
        w_auto_fmt = IMM_ILL;
        case (w_opcode)
            OP_LOAD, OP_JALR: w_auto_fmt = IMM_I;
            // Only slli/srli/srai use the shamt field; other OP-IMM ops are I.
            OP_IMM:    w_auto_fmt = (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                                    ? IMM_SHAMT : IMM_I;
            OP_STORE:  w_auto_fmt = IMM_S;
            OP_BRANCH: w_auto_fmt = IMM_B;
            OP_JAL:    w_auto_fmt = IMM_J;
            OP_LUI, OP_AUIPC: w_auto_fmt = IMM_U;
            // csrr*i variants carry a 5-bit zero-extended immediate in rs1.
            OP_SYSTEM: w_auto_fmt = w_funct3[2] ? IMM_ZIMM : IMM_I;
            default:   w_auto_fmt = IMM_ILL;
        endcase
    end

    assign fmt     = (AUTO_DECODE != 0) ? w_auto_fmt : imm_src;
    assign illegal = (fmt == IMM_ILL);

endmodule : imm_fmt_decode
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined RISC-V immediate generator (I/S/B/J/U/SHAMT/ZIMM) for
//            XLEN 32 or 64, sitting between decode and execute as a
//            valid/ready stage of STAGES register slices with flush and a
//            pass-through tag.
// Ports    : clk, rst            clock, synchronous active-high reset
//            flush               drop every in-flight entry
//            in_valid/in_ready   input handshake (instr, imm_src, in_tag)
//            out_valid/out_ready output handshake (imm_ext, out_tag, illegal)
//            instr [31:0]        raw instruction
//            imm_src [2:0]       format select (unused when AUTO_DECODE=1)
//            in_tag/out_tag      side-band tag, TAG_W bits
//            imm_ext [XLEN-1:0]  extended immediate (0 when illegal)
//            illegal             unsupported format
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STAGES      = 1,
    parameter int TAG_W       = 32,
    parameter int AUTO_DECODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    // ------------------------------------------------------------------
    // Format selection and extension (combinational, ahead of stage 0)
    // ------------------------------------------------------------------
    logic [2:0]      w_fmt_raw;
    imm_fmt_e        w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;

    imm_fmt_decode #(
        .AUTO_DECODE (AUTO_DECODE)
    ) u_fmt_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .fmt     (w_fmt_raw),
        .illegal (w_illegal)
    );

    assign w_fmt = imm_fmt_e'(w_fmt_raw);

    // Size-casting a $signed operand sign-extends from instr[31]; an
    // unsigned operand zero-extends.
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            IMM_I: w_imm = XLEN'($signed(instr[31:20]));
            IMM_S: w_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B: w_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                          instr[11:8], 1'b0}));
            IMM_J: w_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                          instr[30:21], 1'b0}));
            IMM_U: w_imm = XLEN'($signed({instr[31:12], 12'b0}));
            // RV64 shifts use a 6-bit shamt; RV32 only 5 (bit 25 is funct7).
            IMM_SHAMT: w_imm = (XLEN == 64) ? XLEN'(instr[25:20])
                                            : XLEN'(instr[24:20]);
            IMM_ZIMM:  w_imm = XLEN'(instr[19:15]);
            default:   w_imm = '0;
        endcase
        if (w_illegal) begin
            w_imm = '0;
        end
    end

    // ------------------------------------------------------------------
    // Register pipeline. All stages advance together on w_en; there is no
    // bubble compression, so a stall at the output freezes every stage.
    // ------------------------------------------------------------------
    logic                 w_en;
    logic [STAGES-1:0]    w_vld_q;
    logic [STAGES-1:0]    w_ill_q;
    logic [XLEN-1:0]      w_imm_q [STAGES];
    logic [TAG_W-1:0]     w_tag_q [STAGES];

    assign w_en     = !w_vld_q[STAGES-1] || out_ready;
    assign in_ready = w_en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic             r_valid;
        logic             r_ill;
        logic [XLEN-1:0]  r_imm;
        logic [TAG_W-1:0] r_tag;
        logic             w_d_valid;
        logic             w_d_ill;
        logic [XLEN-1:0]  w_d_imm;
        logic [TAG_W-1:0] w_d_tag;

        if (s == 0) begin : g_head
            // in_ready equals w_en, so on an advance in_valid alone decides
            // whether stage 0 captures a new entry.
            assign w_d_valid = in_valid;
            assign w_d_ill   = w_illegal;
            assign w_d_imm   = w_imm;
            assign w_d_tag   = in_tag;
        end else begin : g_body
            assign w_d_valid = w_vld_q[s-1];
            assign w_d_ill   = w_ill_q[s-1];
            assign w_d_imm   = w_imm_q[s-1];
            assign w_d_tag   = w_tag_q[s-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_ill   <= 1'b0;
                r_imm   <= '0;
                r_tag   <= '0;
            end else if (flush) begin
                // Data is left as-is; only the valid bits matter after flush.
                r_valid <= 1'b0;
            end else if (w_en) begin
                r_valid <= w_d_valid;
                r_ill   <= w_d_ill;
                r_imm   <= w_d_imm;
                r_tag   <= w_d_tag;
            end
        end

        assign w_vld_q[s] = r_valid;
        assign w_ill_q[s] = r_ill;
        assign w_imm_q[s] = r_imm;
        assign w_tag_q[s] = r_tag;
    end

    assign out_valid = w_vld_q[STAGES-1];
    assign illegal   = w_ill_q[STAGES-1];
    assign imm_ext   = w_imm_q[STAGES-1];
    assign out_tag   = w_tag_q[STAGES-1];

endmodule : imm_gen_pipe
`default_nettype wire
